mealy_det_rr_sched: RTL and testbench

//  Time-multiplexes one shared "1011" Mealy sequence-detector datapath across N_CH serial bit channels.

---
 rtl/mealy_det_pkg.sv | 47 ++++
 rtl/mealy_det_rr_sched_arb.sv | 28 ++
 rtl/mealy_det_rr_sched.sv | 94 +++++++++
 tb/tb_mealy_det_rr_sched.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mealy_det_pkg.sv
// Shared types and next-state function for the time-multiplexed "1011" detector.
// Config macro: OVERLAP_EN selects overlapping (S1 after hit) vs non-overlapping (S0) detection.
package mealy_det_pkg;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } det_state_t;

    localparam logic [3:0] PATTERN = 4'b1011;

`ifdef OVERLAP_EN
    // The trailing 1 of a match is also the first bit of the next one.
    localparam det_state_t S_AFTER_HIT = S1;
`else
    localparam det_state_t S_AFTER_HIT = S0;
`endif

    // Returns {hit, next_state}. Fall-back edges are the KMP
    // failure targets for PATTERN.
    function automatic logic [2:0] det_next(
        det_state_t s,
        logic       b
    );
        det_state_t n;
        logic       hit;
        hit = 1'b0;
        n   = S0;
        unique case (s)
            S0: n = (b == PATTERN[3]) ? S1 : S0;
            S1: n = (b == PATTERN[2]) ? S2 : S1;
            S2: n = (b == PATTERN[1]) ? S3 : S0;
            S3: begin
                if (b == PATTERN[0]) begin
                    hit = 1'b1;
                    n   = S_AFTER_HIT;
                end else begin
                    n = S2;
                end
            end
        endcase
        return {hit, n};
    endfunction

endpackage

// File: rtl/mealy_det_rr_sched_arb.sv
// Combinational round-robin arbiter: one-hot grant, search starts at ptr+1.
// Ports: req (N), ptr (last granted index), gnt (one-hot, 0 when req=0).
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt
);

    logic         found;
    logic [W-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = W'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mealy_det_rr_sched.sv
// N_CH serial channels share one "1011" Mealy detector, granted round-robin.
// Ports: clk, rst (sync, high), req/bit_in/ch_clr (N_CH), gnt (comb one-hot),
//        det_valid/det_ch/det_hit/hit_total (registered). Macro: OVERLAP_EN.
module mealy_det_rr_sched
    import mealy_det_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CH_W  = $clog2(N_CH),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  req,
    input  logic [N_CH-1:0]  bit_in,
    input  logic [N_CH-1:0]  ch_clr,
    output logic [N_CH-1:0]  gnt,
    output logic             det_valid,
    output logic [CH_W-1:0]  det_ch,
    output logic             det_hit,
    output logic [CNT_W-1:0] hit_total
);

    det_state_t       st [N_CH];
    logic [CH_W-1:0]  ptr;
    logic [N_CH-1:0]  elig;
    logic [CH_W-1:0]  gidx;
    logic             any;
    det_state_t       cur;
    det_state_t       nxt;
    logic [2:0]       res;
    logic             hit;

    // Clearing channels sit out arbitration so their bit stays pending.
    assign elig = req & ~ch_clr & {N_CH{~rst}};

    rr_arbiter #(
        .N (N_CH),
        .W (CH_W)
    ) u_arb (
        .req (elig),
        .ptr (ptr),
        .gnt (gnt)
    );

    assign any = |gnt;

    always_comb begin
        gidx = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (gnt[c]) gidx = CH_W'(c);
        end
    end

    // Next-state process for the shared detector.
    always_comb begin
        cur = st[gidx];
        res = det_next(cur, bit_in[gidx]);
        nxt = det_state_t'(res[1:0]);
    end

    // Output process: Mealy hit qualified by a real grant.
    assign hit = any & res[2];

    // State register process: the per-channel state file.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) st[c] <= S0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (ch_clr[c])   st[c] <= S0;
                else if (gnt[c]) st[c] <= nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= CH_W'(N_CH - 1);
            det_valid <= 1'b0;
            det_ch    <= '0;
            det_hit   <= 1'b0;
            hit_total <= '0;
        end else begin
            if (any) ptr <= gidx;
            det_valid <= any;
            det_ch    <= gidx;
            det_hit   <= hit;
            // Count moves together with det_hit so both agree in one cycle.
            if (hit && hit_total != {CNT_W{1'b1}})
                hit_total <= hit_total + 1'b1;
        end
    end

endmodule

// File: tb/tb_mealy_det_rr_sched.sv
// Self-checking bench: string-history model plus directed literal checks.
module tb_mealy_det_rr_sched;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req, bit_in, ch_clr, gnt;
    logic         det_valid, det_hit;
    logic [1:0]   det_ch;
    logic [7:0]   hit_total;

    mealy_det_rr_sched #(.N_CH(N), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .bit_in    (bit_in),
        .ch_clr    (ch_clr),
        .gnt       (gnt),
        .det_valid (det_valid),
        .det_ch    (det_ch),
        .det_hit   (det_hit),
        .hit_total (hit_total)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: last bits seen per channel since restart, and how many.
    int         mptr;
    logic [3:0] hist [N];
    int         nb   [N];
    logic       ev, eh;
    int         ech, et;
    logic [N-1:0] last_gnt;
    logic [N-1:0] mgl;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] mgrant(input logic [N-1:0] e);
        logic [N-1:0] g;
        g = '0;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (mptr + k) % N;
            if (g == 0 && e[c]) g[c] = 1'b1;
        end
        return g;
    endfunction

    task automatic model_reset();
        mptr = N - 1;
        for (int c = 0; c < N; c++) begin
            nb[c]   = 0;
            hist[c] = '0;
        end
        ev = 0; eh = 0; ech = 0; et = 0;
    endtask

    task automatic cyc(input logic r, input logic [N-1:0] rq,
                       input logic [N-1:0] bi, input logic [N-1:0] cl);
        logic [N-1:0] mg;
        int g;
        logic h;
        rst = r; req = rq; bit_in = bi; ch_clr = cl;
        #1;
        mg = r ? '0 : mgrant(rq & ~cl);
        chk("gnt", 32'(gnt), 32'(mg));
        chk("valid", 32'(det_valid), 32'(ev));
        if (ev) chk("ch", 32'(det_ch), ech);
        chk("hit", 32'(det_hit), 32'(eh));
        chk("total", 32'(hit_total), et);
        last_gnt = gnt;
        mgl = mg;
        if (r) begin
            model_reset();
        end else begin
            for (int c = 0; c < N; c++) if (cl[c]) nb[c] = 0;
            if (mg != 0) begin
                g = 0;
                for (int c = 0; c < N; c++) if (mg[c]) g = c;
                hist[g] = {hist[g][2:0], bi[g]};
                nb[g]++;
                h = (nb[g] >= 4) && (hist[g] == 4'b1011);
                if (h) begin
                    if (et < 255) et++;
`ifndef OVERLAP_EN
                    nb[g] = 0;
`endif
                end
                ev = 1; eh = h; ech = g; mptr = g;
            end else begin
                ev = 0; eh = 0;
            end
        end
        @(negedge clk);
    endtask

    logic [3:0]   pat;
    logic [6:0]   seq;
    logic [N-1:0] preq, pbit, rq, cl;
    int           hits, i0, i1, exp3;

    initial begin
        rst = 1'b1; req = '0; bit_in = '0; ch_clr = '0;
        model_reset();
        pat = 4'b1011;
        seq = 7'b1011011;
        @(negedge clk);
        cyc(1, 4'b1111, 4'b1111, 4'b0000);
        chk("rst_gnt", 32'(last_gnt), 32'd0);

        // T1: single channel 1,0,1,1
        for (int i = 0; i < 4; i++) begin
            cyc(0, 4'b0001, {3'b000, pat[3-i]}, 4'b0000);
            chk("t1_gnt", 32'(last_gnt), 32'd1);
            chk("t1_valid", 32'(det_valid), 32'd1);
            chk("t1_hit", 32'(det_hit), (i == 3) ? 32'd1 : 32'd0);
        end
        chk("t1_ch", 32'(det_ch), 32'd0);
        cyc(0, 4'b0000, 4'b0000, 4'b0000);

        // T2: two channels interleaved
        cyc(1, 4'b0000, 4'b0000, 4'b0000);
        i0 = 0; i1 = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(0, 4'b0011, {2'b00, pat[3-(i1%4)], pat[3-(i0%4)]}, 4'b0000);
            chk("t2_gnt", 32'(last_gnt), (k % 2 == 0) ? 32'd1 : 32'd2);
            if (last_gnt[0]) i0++;
            if (last_gnt[1]) i1++;
        end
        chk("t2_hit8", 32'(det_hit), 32'd1);
        chk("t2_ch8", 32'(det_ch), 32'd1);
        chk("t2_total", 32'(hit_total), 32'd2);

        // T3: 1011011 on ch0
        cyc(1, 4'b0000, 4'b0000, 4'b0000);
        hits = 0;
        for (int i = 0; i < 7; i++) begin
            cyc(0, 4'b0001, {3'b000, seq[6-i]}, 4'b0000);
            hits += int'(det_hit);
        end
`ifdef OVERLAP_EN
        exp3 = 2;
`else
        exp3 = 1;
`endif
        chk("t3_hits", hits, exp3);

        // T4: clear masks ch2 and discards its partial match
        cyc(1, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 3; i++)
            cyc(0, 4'b0100, {1'b0, pat[3-i], 2'b00}, 4'b0000);
        cyc(0, 4'b0100, 4'b0100, 4'b0100);
        chk("t4_mask", 32'(last_gnt), 32'd0);
        cyc(0, 4'b0100, 4'b0100, 4'b0000);
        chk("t4_gnt", 32'(last_gnt), 32'd4);
        chk("t4_hit", 32'(det_hit), 32'd0);

        // T5: reset mid-stream
        cyc(1, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 3; i++)
            cyc(0, 4'b0001, {3'b000, pat[3-i]}, 4'b0000);
        cyc(1, 4'b0011, 4'b0011, 4'b0000);
        cyc(0, 4'b0011, 4'b0011, 4'b0000);
        chk("t5_gnt", 32'(last_gnt), 32'd1);
        chk("t5_hit", 32'(det_hit), 32'd0);

        // Saturation of hit_total
        cyc(1, 4'b0000, 4'b0000, 4'b0000);
        for (int k = 0; k < 300; k++)
            for (int i = 0; i < 4; i++)
                cyc(0, 4'b0001, {3'b000, pat[3-i]}, 4'b0000);
        chk("sat_total", 32'(hit_total), 32'd255);

        // Random traffic; pending bits held until granted
        cyc(1, 4'b0000, 4'b0000, 4'b0000);
        preq = '0; pbit = '0;
        for (int k = 0; k < 4000; k++) begin
            for (int c = 0; c < N; c++) begin
                if (!preq[c]) begin
                    preq[c] = ($urandom_range(0, 2) != 0);
                    pbit[c] = $urandom_range(0, 3) != 0;
                end
            end
            cl = '0;
            for (int c = 0; c < N; c++)
                cl[c] = ($urandom_range(0, 19) == 0);
            rq = preq;
            cyc(($urandom_range(0, 199) == 0), rq, pbit, cl);
            preq = preq & ~mgl;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
